// File: rtl/mdl_dac_receiver_pkg.sv
// Shared constants and FSM state type for the serial DAC receiver.
package mdl_dac_receiver_pkg;

    localparam int SR_W     = 16;
    localparam int EXP_MSB  = 15;
    localparam int MANT_LSB = 3;
    localparam int EXP_W    = 3;
    localparam int MANT_W   = 10;
    localparam int OUT_W    = 16;
    localparam int WDOG_W   = 6;

    typedef enum logic [1:0] {
        HUNT,
        WAIT_R,
        WAIT_L
    } state_t;

endpackage

// File: rtl/mdl_dac_fp2lin.sv
// Floating-point DAC word {exponent, offset-binary mantissa} to 16-bit signed linear.
module mdl_dac_fp2lin
    import mdl_dac_receiver_pkg::*;
(
    input  logic [EXP_W-1:0]        expo,
    input  logic [MANT_W-1:0]       mant,
    output logic signed [OUT_W-1:0] lin
);

    logic signed [MANT_W-1:0] sman;
    logic signed [OUT_W-1:0]  sext;

    // Flip the mantissa MSB to get two's complement, sign-extend, scale by 2^(e-1); e=0 mutes
    always_comb begin
        sman = {~mant[MANT_W-1], mant[MANT_W-2:0]};
        sext = OUT_W'(sman);
        if (expo == '0) begin
            lin = '0;
        end else begin
            lin = sext <<< (expo - 1'b1);
        end
    end

endmodule

// File: rtl/mdl_dac_receiver.sv
// Receiver for the SO/SH1/SH2 sound link: deserialises, frames L/R words and
// converts them to signed linear samples, with framing and watchdog checks.
module mdl_dac_receiver
    import mdl_dac_receiver_pkg::*;
#(
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = 6'd63
) (
    input  logic                    i_EMUCLK,
    input  logic                    i_IC_n,
    input  logic                    i_phi1_NCEN_n,
    input  logic                    i_SO,
    input  logic                    i_SH1,
    input  logic                    i_SH2,
    output logic signed [OUT_W-1:0] o_L,
    output logic signed [OUT_W-1:0] o_R,
    output logic                    o_SAMPLE_VALID,
    output logic                    o_SYNCED,
    output logic                    o_FRAME_ERR
);

    logic [SR_W-1:0]         sr;
    logic                    sh1_d;
    logic                    sh2_d;
    state_t                  state;
    state_t                  state_nxt;
    logic                    paired;
    logic                    paired_nxt;
    logic [WDOG_W-1:0]       wdog;
    logic [WDOG_W-1:0]       wdog_inc;
    logic                    en;
    logic                    fall1;
    logic                    fall2;
    logic                    any_fall;
    logic                    wdog_trip;
    logic                    lat_l;
    logic                    lat_r;
    logic                    valid;
    logic                    err;
    logic signed [OUT_W-1:0] lin;
    logic                    unused_bits;

    assign en        = ~i_phi1_NCEN_n;
    assign fall1     = en & sh1_d & ~i_SH1;
    assign fall2     = en & sh2_d & ~i_SH2;
    assign any_fall  = fall1 | fall2;
    assign wdog_inc  = (wdog == '1) ? wdog : wdog + 1'b1;
    assign wdog_trip = en && !any_fall && (state != HUNT)
                       && (wdog != WDOG_LIMIT) && (wdog_inc == WDOG_LIMIT);
    assign o_SYNCED  = (state == WAIT_L) || ((state == WAIT_R) && paired);

    // The three low shift-register bits are padding in the word format
    assign unused_bits = sr[0];

    // L and R never latch on the same cycle, so one converter serves both
    mdl_dac_fp2lin u_fp2lin (
        .expo (sr[EXP_MSB -: EXP_W]),
        .mant (sr[MANT_LSB +: MANT_W]),
        .lin  (lin)
    );

    // Framing FSM: next state, latch strobes and error/valid decisions
    always_comb begin
        state_nxt  = state;
        paired_nxt = paired;
        lat_l      = 1'b0;
        lat_r      = 1'b0;
        valid      = 1'b0;
        err        = 1'b0;
        if (fall1 && fall2) begin
            err       = 1'b1;
            state_nxt = HUNT;
        end else begin
            case (state)
                HUNT: begin
                    if (fall1) begin
                        lat_l     = 1'b1;
                        state_nxt = WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (fall2) begin
                        lat_r      = 1'b1;
                        valid      = 1'b1;
                        paired_nxt = 1'b1;
                        state_nxt  = WAIT_L;
                    end else if (fall1) begin
                        err   = 1'b1;
                        lat_l = 1'b1;
                    end
                end
                WAIT_L: begin
                    if (fall1) begin
                        lat_l     = 1'b1;
                        state_nxt = WAIT_R;
                    end else if (fall2) begin
                        err       = 1'b1;
                        state_nxt = HUNT;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
        if (wdog_trip) begin
            err       = 1'b1;
            state_nxt = HUNT;
        end
        if (state_nxt == HUNT) begin
            paired_nxt = 1'b0;
        end
    end

    // FSM state register, advanced only on enabled cycles
    always_ff @(posedge i_EMUCLK) begin
        if (!i_IC_n) begin
            state  <= HUNT;
            paired <= 1'b0;
        end else if (en) begin
            state  <= state_nxt;
            paired <= paired_nxt;
        end
    end

    // Shifting, edge history, watchdog, sample latches and one-clock pulses
    always_ff @(posedge i_EMUCLK) begin
        if (!i_IC_n) begin
            sr             <= '0;
            sh1_d          <= 1'b1;
            sh2_d          <= 1'b1;
            wdog           <= '0;
            o_L            <= '0;
            o_R            <= '0;
            o_SAMPLE_VALID <= 1'b0;
            o_FRAME_ERR    <= 1'b0;
        end else begin
            o_SAMPLE_VALID <= valid;
            o_FRAME_ERR    <= err;
            if (en) begin
                sr    <= {i_SO, sr[SR_W-1:1]};
                sh1_d <= i_SH1;
                sh2_d <= i_SH2;
                wdog  <= any_fall ? '0 : wdog_inc;
                if (lat_l) begin
                    o_L <= lin;
                end
                if (lat_r) begin
                    o_R <= lin;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdl_dac_receiver.sv
// Self-checking bench for mdl_dac_receiver: directed scenarios plus randomized
// frames, compared every cycle against a behavioural model of the link.
module tb_mdl_dac_receiver;

    localparam logic [5:0] LIMIT = 6'd63;

    logic        i_EMUCLK = 1'b0;
    logic        i_IC_n;
    logic        i_phi1_NCEN_n;
    logic        i_SO;
    logic        i_SH1;
    logic        i_SH2;
    logic [15:0] o_L;
    logic [15:0] o_R;
    logic        o_SAMPLE_VALID;
    logic        o_SYNCED;
    logic        o_FRAME_ERR;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int n_ferr   = 0;
    bit gaps     = 1'b0;

    // behavioural model state
    bit          hist[$];        // last 16 received bits, oldest first
    logic [15:0] m_l, m_r;
    bit          m_valid, m_err;
    bit          m_hunt, m_wait_r, m_paired;
    int          m_idle;
    bit          m_prev1, m_prev2;

    mdl_dac_receiver #(.WDOG_LIMIT(LIMIT)) dut (
        .i_EMUCLK       (i_EMUCLK),
        .i_IC_n         (i_IC_n),
        .i_phi1_NCEN_n  (i_phi1_NCEN_n),
        .i_SO           (i_SO),
        .i_SH1          (i_SH1),
        .i_SH2          (i_SH2),
        .o_L            (o_L),
        .o_R            (o_R),
        .o_SAMPLE_VALID (o_SAMPLE_VALID),
        .o_SYNCED       (o_SYNCED),
        .o_FRAME_ERR    (o_FRAME_ERR)
    );

    always #5 i_EMUCLK = ~i_EMUCLK;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] mkw(input logic [2:0] e, input logic [9:0] m);
        return {e, m, 3'b000};
    endfunction

    // value of the 16 most recent bits, first-received bit as LSB
    function automatic int hist_word();
        int w = 0;
        for (int i = 0; i < 16; i++) if (hist[i]) w += (1 << i);
        return w;
    endfunction

    // linear value = (mantissa - 512) * 2^(e-1), muted for e = 0
    function automatic logic [15:0] ref_lin(input int w);
        int e, m, v;
        e = (w >> 13) & 7;
        m = (w >> 3) & 1023;
        if (e == 0) return 16'h0000;
        v = (m - 512) * (1 << (e - 1));
        return 16'(v);
    endfunction

    function automatic bit exp_synced();
        return !m_hunt && (!m_wait_r || m_paired);
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 16; i++) hist.push_back(1'b0);
        m_l = '0; m_r = '0; m_valid = 0; m_err = 0;
        m_hunt = 1; m_wait_r = 0; m_paired = 0; m_idle = 0;
        m_prev1 = 1; m_prev2 = 1;
    endtask

    task automatic model_step(input bit so, input bit sh1, input bit sh2);
        bit f1, f2;
        int w;
        m_valid = 0;
        m_err   = 0;
        f1 = m_prev1 && !sh1;
        f2 = m_prev2 && !sh2;
        w  = hist_word();
        if (f1 && f2) begin
            m_err = 1; m_hunt = 1; m_wait_r = 0; m_paired = 0;
        end else if (f1) begin
            m_l = ref_lin(w);
            if (!m_hunt && m_wait_r) m_err = 1;
            m_hunt = 0; m_wait_r = 1;
        end else if (f2) begin
            if (!m_hunt) begin
                if (m_wait_r) begin
                    m_r = ref_lin(w); m_valid = 1; m_paired = 1; m_wait_r = 0;
                end else begin
                    m_err = 1; m_hunt = 1; m_paired = 0;
                end
            end
        end
        if (f1 || f2) begin
            m_idle = 0;
        end else begin
            if (m_idle < 63) m_idle++;
            if (!m_hunt && m_idle == int'(LIMIT)) begin
                m_err = 1; m_hunt = 1; m_wait_r = 0; m_paired = 0;
            end
        end
        hist.push_back(so);
        void'(hist.pop_front());
        m_prev1 = sh1;
        m_prev2 = sh2;
    endtask

    // one EMUCLK cycle: drive, advance model, then check all outputs
    task automatic step(input bit so, input bit sh1, input bit sh2, input bit en, input bit rst_n);
        i_SO = so; i_SH1 = sh1; i_SH2 = sh2;
        i_phi1_NCEN_n = !en; i_IC_n = rst_n;
        if (!rst_n) model_reset();
        else if (en) model_step(so, sh1, sh2);
        else begin m_valid = 0; m_err = 0; end
        @(posedge i_EMUCLK);
        #1;
        check_val("o_L", 32'(o_L), 32'(m_l));
        check_val("o_R", 32'(o_R), 32'(m_r));
        check_val("o_SAMPLE_VALID", 32'(o_SAMPLE_VALID), 32'(m_valid));
        check_val("o_FRAME_ERR", 32'(o_FRAME_ERR), 32'(m_err));
        check_val("o_SYNCED", 32'(o_SYNCED), 32'(exp_synced()));
        if (o_SAMPLE_VALID === 1'b1) n_valid++;
        if (o_FRAME_ERR === 1'b1) n_ferr++;
    endtask

    // enabled cycle, optionally preceded by disabled cycles carrying junk
    task automatic ecyc(input bit so, input bit sh1, input bit sh2);
        int n;
        n = gaps ? int'($urandom_range(0, 2)) : 0;
        for (int j = 0; j < n; j++) step(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1);
        step(so, sh1, sh2, 1'b1, 1'b1);
    endtask

    task automatic half(input logic [15:0] w, input bit sh1, input bit sh2, input int pause_at);
        for (int i = 0; i < 16; i++) begin
            if (i == pause_at)
                for (int j = 0; j < 100; j++) step(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1);
            ecyc(w[i], sh1, sh2);
        end
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r);
        half(l, 1'b1, 1'b0, -1);
        half(r, 1'b0, 1'b1, -1);
    endtask

    task automatic flush();
        ecyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int v0, e0, k;
        logic [15:0] wa, wb, wc, wd;

        // reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("rst_L", 32'(o_L), 'h0);
        check_val("rst_R", 32'(o_R), 'h0);
        check_val("rst_synced", 32'(o_SYNCED), 0);
        check_val("rst_valid", 32'(o_SAMPLE_VALID), 0);

        // nominal frame, extreme exponents
        v0 = n_valid; e0 = n_ferr;
        frame(mkw(3'd7, 10'h3FF), mkw(3'd1, 10'h000));
        flush();
        check_val("tp1_L", 32'(o_L), 'h7FC0);
        check_val("tp1_R", 32'(o_R), 'hFE00);
        check_val("tp1_valid_cnt", n_valid - v0, 1);
        check_val("tp1_err_cnt", n_ferr - e0, 0);
        check_val("tp1_synced", 32'(o_SYNCED), 1);

        // mute and near-zero mantissas
        gaps = 1'b1;
        frame(mkw(3'd0, 10'($urandom)), mkw(3'd0, 10'($urandom)));
        flush();
        check_val("mute_L", 32'(o_L), 'h0);
        check_val("mute_R", 32'(o_R), 'h0);
        frame(mkw(3'd4, 10'h200), mkw(3'd4, 10'h201));
        flush();
        check_val("e4_m200", 32'(o_L), 'h0);
        check_val("e4_m201", 32'(o_R), 'h8);

        // two SH1 falls with no SH2 fall between
        v0 = n_valid; e0 = n_ferr;
        wa = 16'($urandom); wb = 16'($urandom); wc = mkw(3'd5, 10'($urandom)); wd = 16'($urandom);
        half(wa, 1'b1, 1'b0, -1);
        half(wb, 1'b0, 1'b0, -1);
        half(wc, 1'b1, 1'b0, -1);
        flush();
        check_val("sh1x2_err_cnt", n_ferr - e0, 1);
        check_val("sh1x2_no_valid", n_valid - v0, 0);
        check_val("sh1x2_relatch", 32'(o_L), 32'(ref_lin(int'(wc))));
        half(wd, 1'b0, 1'b1, -1);
        flush();
        check_val("sh1x2_valid_after", n_valid - v0, 1);
        check_val("sh1x2_synced", 32'(o_SYNCED), 1);

        // watchdog: strobes stop while synced
        e0 = n_ferr;
        for (int i = 0; i < 62; i++) ecyc(1'($urandom), 1'b0, 1'b0);
        check_val("wdog_early", n_ferr - e0, 0);
        check_val("wdog_early_synced", 32'(o_SYNCED), 1);
        ecyc(1'b0, 1'b0, 1'b0);
        check_val("wdog_err", n_ferr - e0, 1);
        check_val("wdog_unsynced", 32'(o_SYNCED), 0);
        v0 = n_valid; e0 = n_ferr;
        half(16'($urandom), 1'b0, 1'b1, -1);
        flush();
        check_val("hunt_sh2_no_valid", n_valid - v0, 0);
        check_val("hunt_sh2_no_err", n_ferr - e0, 0);
        frame(16'($urandom), 16'($urandom));
        flush();
        check_val("wdog_recover_valid", n_valid - v0, 1);
        check_val("wdog_recover_synced", 32'(o_SYNCED), 1);

        // enable held off for 100 clocks mid-frame
        v0 = n_valid; e0 = n_ferr;
        wa = 16'($urandom); wb = 16'($urandom);
        half(wa, 1'b1, 1'b0, -1);
        half(wb, 1'b0, 1'b1, 8);
        flush();
        check_val("pause_no_err", n_ferr - e0, 0);
        check_val("pause_valid", n_valid - v0, 1);
        check_val("pause_R", 32'(o_R), 32'(ref_lin(int'(wb))));

        // one-clock reset mid-frame without enable
        wa = 16'($urandom);
        for (int i = 0; i < 8; i++) ecyc(wa[i], 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("midrst_L", 32'(o_L), 'h0);
        check_val("midrst_R", 32'(o_R), 'h0);
        check_val("midrst_synced", 32'(o_SYNCED), 0);
        v0 = n_valid;
        wb = 16'($urandom);
        frame(mkw(3'd7, 10'h3FF), wb);
        flush();
        check_val("postrst_L", 32'(o_L), 'h7FC0);
        check_val("postrst_R", 32'(o_R), 32'(ref_lin(int'(wb))));
        check_val("postrst_valid", n_valid - v0, 1);

        // simultaneous SH1/SH2 fall
        v0 = n_valid; e0 = n_ferr;
        half(16'($urandom), 1'b1, 1'b1, -1);
        flush();
        check_val("both_err", n_ferr - e0, 1);
        check_val("both_unsynced", 32'(o_SYNCED), 0);
        check_val("both_no_latch", 32'(o_L), 'h7FC0);
        check_val("both_no_valid", n_valid - v0, 0);

        // randomized traffic with occasional framing faults and stalls
        for (int f = 0; f < 40; f++) begin
            k = int'($urandom_range(0, 7));
            if (k == 0) half(16'($urandom), 1'($urandom), 1'($urandom), -1);
            else if (k == 1) for (int i = 0; i < 70; i++) ecyc(1'($urandom), 1'b0, 1'b0);
            else frame(16'($urandom), 16'($urandom));
        end
        frame(16'($urandom), 16'($urandom));
        frame(16'($urandom), 16'($urandom));
        flush();
        check_val("rand_end_synced", 32'(o_SYNCED), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
